// File: rtl/aesl_deadlock_timeout_monitor.sv
// Deadlock watchdog for one HLS kernel: declares deadlock after TIMEOUT consecutive
// stall cycles, then latches a sticky flag plus a snapshot of the blocked AXIS channels.
module aesl_deadlock_timeout_monitor #(
    parameter int N_AXIS  = 2,
    parameter int N_INST  = 1,
    parameter int TIMEOUT = 1024,
    parameter int EVT_W   = 8,
    localparam int CNT_W  = $clog2(TIMEOUT + 1),
    localparam int IDX_W  = (N_AXIS > 1) ? $clog2(N_AXIS) : 1
) (
    input  logic              kernel_monitor_clock,
    input  logic              kernel_monitor_reset,
    input  logic              enable,
    input  logic              clear,
    input  logic [N_AXIS-1:0] axis_block_sigs,
    input  logic [N_INST-1:0] inst_idle_sigs,
    input  logic [N_INST-1:0] inst_block_sigs,
    output logic              block,
    output logic              block_pulse,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [N_AXIS-1:0] snap_axis,
    output logic [IDX_W-1:0]  first_axis_idx,
    output logic [EVT_W-1:0]  event_cnt
);

    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("aesl_deadlock_timeout_monitor: TIMEOUT must be >= 2");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_WATCH,
        S_DEADLOCK
    } state_e;

    state_e              state_q, state_d;
    logic                block_q, block_d;
    logic                block_pulse_q, block_pulse_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic [N_AXIS-1:0]   snap_axis_q, snap_axis_d;
    logic [IDX_W-1:0]    first_axis_idx_q, first_axis_idx_d;
    logic [EVT_W-1:0]    event_cnt_q, event_cnt_d;
    logic                stall;
    logic [IDX_W-1:0]    lowest_idx;

    // Every instance must be either idle or blocked, and at least one channel must be blocked.
    assign stall = enable & (|axis_block_sigs) & (&(inst_block_sigs | inst_idle_sigs));

    // NOTE: assign a default before any conditional write in always_comb, otherwise a latch is inferred.
    always_comb begin
        lowest_idx = '0;
        for (int i = N_AXIS - 1; i >= 0; i--) begin
            if (axis_block_sigs[i]) lowest_idx = IDX_W'(i);
        end
    end

    always_comb begin
        state_d          = state_q;
        block_d          = block_q;
        block_pulse_d    = 1'b0;
        stall_cnt_d      = stall_cnt_q;
        snap_axis_d      = snap_axis_q;
        first_axis_idx_d = first_axis_idx_q;
        event_cnt_d      = event_cnt_q;
        case (state_q)
            S_IDLE: begin
                stall_cnt_d = '0;
                if (!clear && stall) begin
                    state_d     = S_WATCH;
                    stall_cnt_d = CNT_W'(1);
                end
            end
            S_WATCH: begin
                if (clear || !stall) begin
                    state_d     = S_IDLE;
                    stall_cnt_d = '0;
                end else if (stall_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d          = S_DEADLOCK;
                    block_d          = 1'b1;
                    block_pulse_d    = 1'b1;
                    snap_axis_d      = axis_block_sigs;
                    first_axis_idx_d = lowest_idx;
                    stall_cnt_d      = CNT_W'(TIMEOUT);
                    if (event_cnt_q != {EVT_W{1'b1}}) event_cnt_d = event_cnt_q + EVT_W'(1);
                end else begin
                    stall_cnt_d = stall_cnt_q + CNT_W'(1);
                end
            end
            S_DEADLOCK: begin
                // Only clear leaves deadlock; the diagnostic snapshot survives it.
                if (clear) begin
                    state_d     = S_IDLE;
                    block_d     = 1'b0;
                    stall_cnt_d = '0;
                end
            end
            default: begin
                state_d     = S_IDLE;
                block_d     = 1'b0;
                stall_cnt_d = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge kernel_monitor_clock) begin
        if (kernel_monitor_reset) begin
            state_q          <= S_IDLE;
            block_q          <= 1'b0;
            block_pulse_q    <= 1'b0;
            stall_cnt_q      <= '0;
            snap_axis_q      <= '0;
            first_axis_idx_q <= '0;
            event_cnt_q      <= '0;
        end else begin
            state_q          <= state_d;
            block_q          <= block_d;
            block_pulse_q    <= block_pulse_d;
            stall_cnt_q      <= stall_cnt_d;
            snap_axis_q      <= snap_axis_d;
            first_axis_idx_q <= first_axis_idx_d;
            event_cnt_q      <= event_cnt_d;
        end
    end

    // A clear arriving in the entry cycle suppresses the strobe.
    assign block_pulse    = block_pulse_q & ~clear;
    assign block          = block_q;
    assign stall_cnt      = stall_cnt_q;
    assign snap_axis      = snap_axis_q;
    assign first_axis_idx = first_axis_idx_q;
    assign event_cnt      = event_cnt_q;

endmodule
